mdu_seq: RTL and testbench

Iterative 32-bit multiply/divide unit producing the `outHigh`/`outLow` product pair and the `quotient`/`residue` pair that the ALU drives onto its wide-result outputs.
- Replaces single-cycle combinational `mult`/`div` arithmetic with a shift-add / restoring-subtract datapath: one bit per clock, start/busy/done handshake.
- Sits directly upstream of the ALU result mux; the ALU forwards this block's registered results and flags.

---
 rtl/mdu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32-bit multiply/divide, one bit per clock (shift-add / restoring).
// Define MDU_DIV_EN to build the divide datapath with its V/DZ flags.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outHigh,
    output logic [WIDTH-1:0] outLow,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] residue,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             DZ
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d, xneg_q, xneg_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
    logic [WIDTH-1:0] ohi_q, ohi_d, olo_q, olo_d;
    logic [WIDTH-1:0] quo_q, quo_d, res_q, res_d;
    logic             z_q, z_d, n_q, n_d, dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     msum;
    logic [WIDTH-1:0]   mhi, mlo;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = sign & A[WIDTH-1];
    assign b_neg = sign & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // hi:lo is the product accumulator; lo starts as the multiplier and shifts out
    assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign mhi  = msum[WIDTH:1];
    assign mlo  = {msum[0], lo_q[WIDTH-1:1]};
    assign prod = xneg_q ? -{mhi, mlo} : {mhi, mlo};

`ifdef MDU_DIV_EN
    logic             op_q, op_d, aneg_q, aneg_d;
    logic             dzp_q, dzp_d, ovp_q, ovp_d, v_q, v_d;
    logic [WIDTH:0]   dsh, ddif;
    logic [WIDTH-1:0] dhi, dlo, qfix, rfix;

    // hi is the partial remainder, lo the dividend shifting into the quotient
    assign dsh  = {hi_q, lo_q[WIDTH-1]};
    assign ddif = dsh - {1'b0, opd_q};
    assign dhi  = ddif[WIDTH] ? dsh[WIDTH-1:0] : ddif[WIDTH-1:0];
    assign dlo  = {lo_q[WIDTH-2:0], ~ddif[WIDTH]};
    assign qfix = dzp_q ? '1 : (xneg_q ? -dlo : dlo);
    assign rfix = aneg_q ? -dhi : dhi;
    assign V    = v_q;
    assign DZ   = dz_q;
`else
    assign V    = 1'b0;
    assign DZ   = dz_q & (state_q == DONE);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        xneg_d  = xneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        ohi_d   = ohi_q;
        olo_d   = olo_q;
        quo_d   = quo_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        dz_d    = dz_q;
`ifdef MDU_DIV_EN
        op_d    = op_q;
        aneg_d  = aneg_q;
        dzp_d   = dzp_q;
        ovp_d   = ovp_q;
        v_d     = v_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sign_d  = sign;
                    xneg_d  = a_neg ^ b_neg;
                    hi_d    = '0;
                    lo_d    = b_mag;
                    opd_d   = a_mag;
                    dz_d    = 1'b0;
`ifdef MDU_DIV_EN
                    op_d    = op;
                    aneg_d  = a_neg;
                    dzp_d   = (B == '0);
                    ovp_d   = sign && (A == {1'b1, {(WIDTH-1){1'b0}}})
                              && (B == '1);
                    v_d     = 1'b0;
                    if (op) begin
                        lo_d  = a_mag;
                        opd_d = b_mag;
                    end
`else
                    if (op) begin
                        state_d = DONE;
                        quo_d   = '0;
                        res_d   = '0;
                        dz_d    = 1'b1;
                        z_d     = 1'b1;
                        n_d     = 1'b0;
                    end
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                hi_d  = mhi;
                lo_d  = mlo;
`ifdef MDU_DIV_EN
                if (op_q) begin
                    hi_d = dhi;
                    lo_d = dlo;
                end
`endif
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    ohi_d   = prod[2*WIDTH-1:WIDTH];
                    olo_d   = prod[WIDTH-1:0];
                    z_d     = (prod == '0);
                    n_d     = sign_q & prod[2*WIDTH-1];
`ifdef MDU_DIV_EN
                    if (op_q) begin
                        ohi_d = ohi_q;
                        olo_d = olo_q;
                        quo_d = qfix;
                        res_d = rfix;
                        z_d   = (qfix == '0);
                        n_d   = sign_q & qfix[WIDTH-1];
                        dz_d  = dzp_q;
                        v_d   = ovp_q;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            xneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            ohi_q   <= '0;
            olo_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MDU_DIV_EN
            op_q    <= 1'b0;
            aneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            ovp_q   <= 1'b0;
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            xneg_q  <= xneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            ohi_q   <= ohi_d;
            olo_q   <= olo_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            dz_q    <= dz_d;
`ifdef MDU_DIV_EN
            op_q    <= op_d;
            aneg_q  <= aneg_d;
            dzp_q   <= dzp_d;
            ovp_q   <= ovp_d;
            v_q     <= v_d;
`endif
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign outHigh  = ohi_q;
    assign outLow   = olo_q;
    assign quotient = quo_q;
    assign residue  = res_q;
    assign Z        = z_q;
    assign N        = n_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: random and directed operations against an arithmetic reference model.
// Expectations follow MDU_DIV_EN the same way the design does.
module tb_mdu_seq;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, op, sign;
    logic [W-1:0]  A, B;
    logic          busy, done, Z, N, V, DZ;
    logic [W-1:0]  outHigh, outLow, quotient, residue;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
        .A(A), .B(B), .busy(busy), .done(done),
        .outHigh(outHigh), .outLow(outLow),
        .quotient(quotient), .residue(residue),
        .Z(Z), .N(N), .V(V), .DZ(DZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    logic [W-1:0] e_hi, e_lo, e_q, e_r;
    logic         e_z, e_n, e_v, e_dz;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic o, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o) begin
            p    = 64'(sa * sb);
            e_hi = p[63:32];
            e_lo = p[31:0];
            e_z  = (p == 64'd0);
            e_n  = s & p[63];
            if (!DIV_EN) begin
                e_dz = 1'b0;
            end
            e_v  = 1'b0;
            e_dz = 1'b0;
        end else begin
            e_v  = 1'b0;
            e_dz = 1'b0;
            if (!DIV_EN) begin
                e_q  = '0;
                e_r  = '0;
                e_dz = 1'b1;
            end else if (b == '0) begin
                e_q  = '1;
                e_r  = a;
                e_dz = 1'b1;
            end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e_q = 32'h8000_0000;
                e_r = '0;
                e_v = 1'b1;
            end else begin
                e_q = 32'(sa / sb);
                e_r = 32'(sa % sb);
            end
            e_z = (e_q == '0);
            e_n = s & e_q[31];
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_hi"}, outHigh, e_hi);
        check({tag, "_lo"}, outLow, e_lo);
        check({tag, "_quo"}, quotient, e_q);
        check({tag, "_res"}, residue, e_r);
        check({tag, "_flags"}, {Z, N, V, DZ}, {e_z, e_n, e_v, e_dz});
    endtask

    // Called #1 after an edge; returns #1 after the edge where done is seen.
    task automatic run_op(input logic o, input logic s,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, output int done_at);
        int lat;
        bit busy_bad;
        start = 1'b1; op = o; sign = s; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; op = 1'($urandom); sign = 1'($urandom);
        model(o, s, a, b);
        lat = 0;
        busy_bad = 1'b0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            start = (lat == poke);
            if (start) begin
                A = $urandom; B = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, (o && !DIV_EN) ? 0 : W);
        check("busy_run", busy_bad, 0);
        check("busy_at_done", busy, 0);
        check_outs("res");
        done_at = cyc;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_pulse", {busy, done}, 2'b00);
        check("idle_hold", {outLow, quotient}, {e_lo, e_q});
        check("idle_vdz", {V, DZ}, DIV_EN ? {e_v, e_dz} : 2'b00);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0, t1, lat;
        bit seen;
        reset = 1'b1; start = 1'b0; op = 1'b0; sign = 1'b0; A = '0; B = '0;
        e_hi = '0; e_lo = '0; e_q = '0; e_r = '0;
        e_z = 0; e_n = 0; e_v = 0; e_dz = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_done", {busy, done}, 2'b00);
        check_outs("rst");
        reset = 1'b0;
        idle_cycle();

        // unsigned max*max, with an ignored start pulse mid-run
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, t0);
        check("tp_umul", {outHigh, outLow}, 64'hFFFF_FFFE_0000_0001);
        // back-to-back: start during the DONE cycle
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, -1, t1);
        check("b2b_spacing", t1 - t0, W + 1);
        check("tp_smul", {outHigh, outLow, N}, {64'hFFFF_FFFF_FFFF_FFEB, 1'b1});
        idle_cycle();

        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, t0);
        run_op(1'b1, 1'b0, 32'd7, 32'd0, -1, t0);
        check("dz_flag", DZ, 1'b1);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, t0);
        idle_cycle();

        // reset mid-run
        start = 1'b1; op = 1'b0; sign = 1'b0; A = 32'd1234; B = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 14) begin
            @(posedge clk); #1;
            lat++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e_hi = '0; e_lo = '0; e_q = '0; e_r = '0;
        e_z = 0; e_n = 0; e_v = 0; e_dz = 0;
        check("abort_busy_done", {busy, done}, 2'b00);
        check_outs("abort");
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        run_op(1'b0, 1'b0, 32'd1234, 32'd5678, -1, t0);

        repeat (40) begin
            run_op(1'($urandom), 1'($urandom), pick(), pick(), -1, t0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
